// File: rtl/sha_start_sequencer_if.sv
// HPS start/done handshake plus SHA-core control bundle for the start sequencer.
// slave is the sequencer side; master is the HPS/core side that drives it.
interface sha_start_sequencer_if #(
   parameter int unsigned BLK_W = 8
);
   logic             start_in;
   logic [BLK_W-1:0] nblocks;
   logic             core_ready;
   logic             core_digest_valid;
   logic             core_init;
   logic             core_next;
   logic [BLK_W-1:0] blk_idx;
   logic             busy;
   logic             done_out;
   logic             error;

   modport slave (
      input  start_in, nblocks, core_ready, core_digest_valid,
      output core_init, core_next, blk_idx, busy, done_out, error
   );

   modport master (
      output start_in, nblocks, core_ready, core_digest_valid,
      input  core_init, core_next, blk_idx, busy, done_out, error
   );
endinterface

// File: rtl/sha_start_sequencer.sv
// Drives SHA-256 init/next pulses for a multi-block job launched by an HPS start edge,
// reporting completion or timeout back over a four-phase done/start level handshake.
module sha_start_sequencer #(
   parameter int unsigned BLK_W   = 8,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned TO_W    = 11
) (
   input logic                   clk,
   input logic                   reset_n,
   sha_start_sequencer_if.slave  bus
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE,
      S_ERR
   } state_e;

   state_e           state_q, state_d;
   logic             start_q;
   logic [BLK_W-1:0] n_lat_q, n_lat_d;
   logic [BLK_W-1:0] blk_idx_q, blk_idx_d;
   logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             init_q, init_d;
   logic             next_q, next_d;
   logic             start_rise_c;

   assign start_rise_c = bus.start_in & ~start_q;

   // start_q resets high so a start level held through reset is not taken as an edge
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         start_q   <= 1'b1;
         n_lat_q   <= '0;
         blk_idx_q <= '0;
         to_cnt_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         init_q    <= 1'b0;
         next_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         start_q   <= bus.start_in;
         n_lat_q   <= n_lat_d;
         blk_idx_q <= blk_idx_d;
         to_cnt_q  <= to_cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
         init_q    <= init_d;
         next_q    <= next_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      n_lat_d   = n_lat_q;
      blk_idx_d = blk_idx_q;
      to_cnt_d  = to_cnt_q;
      busy_d    = busy_q;
      done_d    = done_q;
      error_d   = error_q;
      init_d    = 1'b0;
      next_d    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_rise_c) begin
               n_lat_d   = bus.nblocks;
               blk_idx_d = '0;
               error_d   = 1'b0;
               if (bus.nblocks == '0) begin
                  state_d = S_ERR;
                  done_d  = 1'b1;
                  error_d = 1'b1;
               end else begin
                  state_d = S_ISSUE;
                  busy_d  = 1'b1;
               end
            end
         end
         S_ISSUE: begin
            if (bus.core_ready) begin
               if (blk_idx_q == '0) init_d = 1'b1;
               else                 next_d = 1'b1;
               to_cnt_d = '0;
               state_d  = S_WAIT;
            end
         end
         S_WAIT: begin
            // a digest arriving on the terminal-count cycle takes priority over timeout
            if (bus.core_digest_valid) begin
               if (blk_idx_q == n_lat_q - BLK_W'(1)) begin
                  state_d = S_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  blk_idx_d = blk_idx_q + BLK_W'(1);
                  state_d   = S_ISSUE;
               end
            end else if (to_cnt_q == TO_LAST) begin
               state_d = S_ERR;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               error_d = 1'b1;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         S_DONE, S_ERR: begin
            if (!bus.start_in) begin
               state_d = S_IDLE;
               done_d  = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.core_init = init_q;
   assign bus.core_next = next_q;
   assign bus.blk_idx   = blk_idx_q;
   assign bus.busy      = busy_q;
   assign bus.done_out  = done_q;
   assign bus.error     = error_q;

endmodule

// File: tb/tb_sha_start_sequencer.sv
// Directed bench for sha_start_sequencer: reset/start gating, multi-block jobs,
// zero-length and timeout errors, ready stalls, ignored inputs and mid-job reset.
module tb_sha_start_sequencer;

   localparam int unsigned BLK_W   = 8;
   localparam int unsigned TIMEOUT = 1024;
   localparam int unsigned TO_W    = 11;

   logic clk;
   logic reset_n;
   int   compared;
   int   mismatched;

   sha_start_sequencer_if #(.BLK_W(BLK_W)) bus ();

   sha_start_sequencer #(
      .BLK_W  (BLK_W),
      .TIMEOUT(TIMEOUT),
      .TO_W   (TO_W)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drop start for one edge, then raise it; returns one sample after acceptance.
   task automatic start_job(input logic [BLK_W-1:0] n);
      bus.nblocks  = n;
      bus.start_in = 1'b0;
      step(1);
      bus.start_in = 1'b1;
      step(1);
   endtask

   task automatic wait_pulse(input string tag, input logic exp_init, input logic [BLK_W-1:0] exp_idx);
      int n;
      n = 0;
      while (!(bus.core_init || bus.core_next) && n < 50) begin
         step(1);
         n++;
      end
      check({tag, "_seen"}, 32'(n < 50), 32'd1);
      check({tag, "_init"}, 32'(bus.core_init), 32'(exp_init));
      check({tag, "_next"}, 32'(bus.core_next), 32'(!exp_init));
      check({tag, "_idx"}, 32'(bus.blk_idx), 32'(exp_idx));
   endtask

   // One block: pulse, confirm it is single-cycle, then return a digest 5 cycles later.
   task automatic run_block(input string tag, input logic exp_init, input logic [BLK_W-1:0] exp_idx);
      wait_pulse(tag, exp_init, exp_idx);
      step(1);
      check({tag, "_pulse_end"}, 32'({bus.core_init, bus.core_next}), 32'd0);
      step(3);
      check({tag, "_idx_hold"}, 32'(bus.blk_idx), 32'(exp_idx));
      bus.core_digest_valid = 1'b1;
      step(1);
      bus.core_digest_valid = 1'b0;
   endtask

   initial begin
      logic seen;
      compared              = 0;
      mismatched            = 0;
      reset_n               = 1'b0;
      bus.start_in          = 1'b1;
      bus.nblocks           = '0;
      bus.core_ready        = 1'b1;
      bus.core_digest_valid = 1'b0;

      // 1: start held high through reset is not accepted
      step(3);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done_out), 32'd0);
      check("rst_error", 32'(bus.error), 32'd0);
      check("rst_pulses", 32'({bus.core_init, bus.core_next}), 32'd0);
      check("rst_idx", 32'(bus.blk_idx), 32'd0);
      reset_n = 1'b1;
      seen    = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step(1);
         seen = seen | bus.core_init | bus.core_next | bus.busy | bus.done_out;
      end
      check("t1_held_start_ignored", 32'(seen), 32'd0);
      start_job(8'd1);
      check("t1_busy", 32'(bus.busy), 32'd1);
      check("t1_no_early_init", 32'(bus.core_init), 32'd0);
      run_block("t1b0", 1'b1, 8'd0);
      check("t1_done", 32'(bus.done_out), 32'd1);
      bus.start_in = 1'b0;
      step(1);
      check("t1_done_clr", 32'(bus.done_out), 32'd0);

      // 2: three blocks; nblocks changed after acceptance has no effect
      start_job(8'd3);
      bus.nblocks = 8'd1;
      run_block("t2b0", 1'b1, 8'd0);
      run_block("t2b1", 1'b0, 8'd1);
      run_block("t2b2", 1'b0, 8'd2);
      check("t2_done", 32'(bus.done_out), 32'd1);
      check("t2_busy", 32'(bus.busy), 32'd0);
      check("t2_error", 32'(bus.error), 32'd0);
      check("t2_idx_final", 32'(bus.blk_idx), 32'd2);
      step(2);
      check("t2_done_hold", 32'(bus.done_out), 32'd1);
      bus.start_in = 1'b0;
      step(1);
      check("t2_done_clr", 32'(bus.done_out), 32'd0);

      // 3: zero-length job errors; error is sticky until next acceptance
      start_job(8'd0);
      check("t3_error", 32'(bus.error), 32'd1);
      check("t3_done", 32'(bus.done_out), 32'd1);
      check("t3_busy", 32'(bus.busy), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         seen = seen | bus.core_init | bus.core_next;
      end
      check("t3_no_pulse", 32'(seen), 32'd0);
      bus.start_in = 1'b0;
      step(1);
      check("t3_done_clr", 32'(bus.done_out), 32'd0);
      check("t3_error_sticky", 32'(bus.error), 32'd1);
      start_job(8'd1);
      check("t3_error_cleared", 32'(bus.error), 32'd0);
      run_block("t3b0", 1'b1, 8'd0);
      check("t3_done2", 32'(bus.done_out), 32'd1);
      bus.start_in = 1'b0;
      step(1);

      // 4: timeout exactly TIMEOUT cycles after core_init, then valid on terminal count
      start_job(8'd1);
      wait_pulse("t4a", 1'b1, 8'd0);
      step(TIMEOUT - 1);
      check("t4a_pre_to_error", 32'(bus.error), 32'd0);
      check("t4a_pre_to_busy", 32'(bus.busy), 32'd1);
      step(1);
      check("t4a_to_error", 32'(bus.error), 32'd1);
      check("t4a_to_done", 32'(bus.done_out), 32'd1);
      check("t4a_to_busy", 32'(bus.busy), 32'd0);
      bus.start_in = 1'b0;
      step(1);
      start_job(8'd1);
      check("t4b_error_cleared", 32'(bus.error), 32'd0);
      wait_pulse("t4b", 1'b1, 8'd0);
      step(TIMEOUT - 1);
      bus.core_digest_valid = 1'b1;
      step(1);
      bus.core_digest_valid = 1'b0;
      check("t4b_done", 32'(bus.done_out), 32'd1);
      check("t4b_error", 32'(bus.error), 32'd0);
      bus.start_in = 1'b0;
      step(1);

      // 5: ready stall, stray start toggles and stray digest_valid are ignored
      bus.core_ready = 1'b0;
      start_job(8'd2);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) bus.start_in = 1'b0;
         if (i == 8) bus.start_in = 1'b1;
         bus.core_digest_valid = (i == 12);
         step(1);
         seen = seen | bus.core_init | bus.core_next;
      end
      bus.core_digest_valid = 1'b0;
      check("t5_stall_no_pulse", 32'(seen), 32'd0);
      check("t5_stall_busy", 32'(bus.busy), 32'd1);
      check("t5_stall_idx", 32'(bus.blk_idx), 32'd0);
      bus.core_ready = 1'b1;
      step(1);
      check("t5_init", 32'(bus.core_init), 32'd1);
      check("t5_next", 32'(bus.core_next), 32'd0);
      step(1);
      check("t5_init_single", 32'(bus.core_init), 32'd0);
      bus.start_in = 1'b0;
      step(1);
      bus.start_in = 1'b1;
      step(1);
      check("t5_busy_after_toggle", 32'(bus.busy), 32'd1);
      bus.core_digest_valid = 1'b1;
      step(1);
      bus.core_digest_valid = 1'b0;
      run_block("t5b1", 1'b0, 8'd1);
      check("t5_done", 32'(bus.done_out), 32'd1);
      check("t5_error", 32'(bus.error), 32'd0);
      bus.start_in = 1'b0;
      step(1);
      check("t5_done_clr", 32'(bus.done_out), 32'd0);

      // 6: reset in WAIT of block 1 of 4, then a fresh full job
      start_job(8'd4);
      run_block("t6b0", 1'b1, 8'd0);
      wait_pulse("t6b1", 1'b0, 8'd1);
      step(2);
      reset_n = 1'b0;
      step(1);
      check("t6_rst_busy", 32'(bus.busy), 32'd0);
      check("t6_rst_done", 32'(bus.done_out), 32'd0);
      check("t6_rst_error", 32'(bus.error), 32'd0);
      check("t6_rst_pulses", 32'({bus.core_init, bus.core_next}), 32'd0);
      check("t6_rst_idx", 32'(bus.blk_idx), 32'd0);
      reset_n = 1'b1;
      start_job(8'd4);
      run_block("t6r0", 1'b1, 8'd0);
      run_block("t6r1", 1'b0, 8'd1);
      run_block("t6r2", 1'b0, 8'd2);
      run_block("t6r3", 1'b0, 8'd3);
      check("t6_done", 32'(bus.done_out), 32'd1);
      check("t6_busy", 32'(bus.busy), 32'd0);
      bus.start_in = 1'b0;
      step(1);
      check("t6_done_clr", 32'(bus.done_out), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
